rab_lookup_arb_fsm: RTL and testbench
=====================================

Name: rab_lookup_arb_fsm

Overview:
N-port generalisation of the RAB lookup-control FSM. A round-robin arbiter picks one of NUM_PORTS slave ports with a pending address and steers the shared TLB lookup to that port. On the next edge the block registers accept/drop, the translated address and the interrupt flags. It then holds the port in WAIT until that port reports completion or an optional watchdog expires. It sits between the per-port AXI address buffers and the shared RAB lookup slices.

Parameters:
AXI_ADDR_WIDTH, 40, width of translated output address
NUM_PORTS, 4, number of arbitrated slave ports (>=2)
TIMEOUT_CYCLES, 0, WAIT watchdog limit in cycles; 0 disables the watchdog
IDX_W, $clog2(NUM_PORTS), width of the grant index (derived, not overridable)

Ports:
Clk_CI  in  1  clock
Rst_RBI  in  1  reset, asynchronous, active-low
addr_valid_i  in  NUM_PORTS  per-port address pending
skip_i  in  NUM_PORTS  per-port bypass/drop request
sent_i  in  NUM_PORTS  per-port transaction forwarded/completed
no_hit_i  in  1  lookup miss for the currently selected port
multiple_hit_i  in  1  lookup hit in more than one slice
no_prot_i  in  1  1 = access permitted
out_addr_i  in  AXI_ADDR_WIDTH  translated address from lookup
master_select_i  in  1  target master from lookup
port_sel_o  out  NUM_PORTS  one-hot lookup mux select (combinational)
accept_o  out  NUM_PORTS  one-cycle accept pulse, granted port
drop_o  out  NUM_PORTS  one-cycle drop pulse, granted port
grant_idx_o  out  IDX_W  index of the last granted port (registered)
out_addr_reg_o  out  AXI_ADDR_WIDTH  registered translated address
master_select_reg_o  out  1  registered master select
busy_o  out  1  1 while in WAIT
int_miss_o  out  1  one-cycle miss interrupt pulse
int_multi_o  out  1  one-cycle multi-hit interrupt pulse
int_prot_o  out  1  one-cycle protection-violation interrupt pulse
int_timeout_o  out  1  one-cycle watchdog interrupt pulse

Behaviour:
- Reset (async, Rst_RBI=0): state READY; rr pointer 0; watchdog counter 0; all outputs 0, including out_addr_reg_o and grant_idx_o.
- States are READY and WAIT. busy_o = (state==WAIT).
- READY arbitration:
  - pick = first i with addr_valid_i[i]=1, scanning rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_PORTS.
  - port_sel_o = onehot(pick) while in READY and any addr_valid_i is set; otherwise 0.
  - port_sel_o is 0 throughout WAIT.
  - Lookup inputs are sampled in the same cycle as port_sel_o (combinational lookup).
- Grant edge (READY, any valid):
  - err = no_hit_i | multiple_hit_i | ~no_prot_i | skip_i[pick].
  - accept_o[pick] <= ~err; drop_o[pick] <= err; all other bits of accept_o/drop_o are 0.
  - int_miss_o <= no_hit_i; int_multi_o <= multiple_hit_i; int_prot_o <= ~no_prot_i.
  - skip_i alone raises no interrupt.
  - out_addr_reg_o <= out_addr_i; master_select_reg_o <= master_select_i; grant_idx_o <= pick.
  - rr_ptr <= (pick+1) mod NUM_PORTS; state <= WAIT; watchdog counter cleared.
  - Latency: valid at cycle t -> accept/drop pulse at t+1.
- Pulse outputs (accept, drop, int_*) are high for exactly one cycle per grant. out_addr_reg_o, master_select_reg_o and grant_idx_o hold until the next grant.
- WAIT:
  - Only sent_i[grant_idx_o] is observed; sent_i bits of other ports are ignored.
  - On sent_i[grant_idx_o]=1: state <= READY.
  - Minimum turnaround: one READY cycle before the next grant. Earliest back-to-back grants are at t and t+2.
- Watchdog (TIMEOUT_CYCLES>0):
  - Counter increments each WAIT cycle without sent.
  - When the counter reaches TIMEOUT_CYCLES-1 with no sent: int_timeout_o pulses on the next edge, state <= READY, counter cleared.
  - sent and expiry in the same cycle: sent wins and no int_timeout_o is raised.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
  - With TIMEOUT_CYCLES=0 the watchdog logic is absent and int_timeout_o is tied to 0.
- No valid in READY: state, rr_ptr and registered outputs are held; pulses are 0.
- addr_valid_i dropping in WAIT has no effect; the block still waits for sent.
- Reset asserted mid-WAIT: immediate return to the reset values. Any pending pulse is lost.

Test Plan:
- Reset then single request: addr_valid_i=4'b0100, hits, no_prot=1, out_addr_i=40'h12_3456_7000 -> next cycle accept_o=4'b0100, out_addr_reg_o=40'h12_3456_7000, grant_idx_o=2, busy_o=1. sent_i[2] -> READY.
- Round-robin fairness: all four ports held valid, sent returned one cycle after each grant -> grant order 0,1,2,3,0, grants spaced 3 cycles apart, no port granted twice before the others.
- Error mapping:
  - no_hit=1 on port 1 -> drop_o=4'b0010, int_miss_o=1 for exactly one cycle.
  - multiple_hit=1 -> int_multi_o=1.
  - no_prot=0 -> int_prot_o=1.
  - skip_i[3] alone -> drop_o[3]=1 with no int_* raised.
- Foreign sent ignored: granted port 0, sent_i=4'b0010 for 5 cycles -> busy_o stays 1. sent_i[0] -> READY.
- Watchdog with TIMEOUT_CYCLES=8: no sent after grant -> int_timeout_o pulses 8 cycles after busy_o rises, busy_o=0. Second run with sent asserted in the expiry cycle -> no int_timeout_o.
- Async reset mid-WAIT, asserted off the clock edge -> all outputs 0 immediately. After release, a request to port 0 is granted with rr_ptr restarted at 0.

Source files
------------

// File: rtl/rab_lookup_arb_fsm.sv
// Round-robin arbiter + lookup-control FSM: steers the shared TLB lookup to one of NUM_PORTS ports.
// Accept/drop and interrupt pulses one cycle after the grant; the granted port is held until it sends or the watchdog fires.
module rab_lookup_arb_fsm #(
   parameter int AXI_ADDR_WIDTH = 40,
   parameter int NUM_PORTS      = 4,
   parameter int TIMEOUT_CYCLES = 0,
   localparam int IDX_W         = $clog2(NUM_PORTS)
) (
   input  logic                      Clk_CI,
   input  logic                      Rst_RBI,
   input  logic [NUM_PORTS-1:0]      addr_valid_i,
   input  logic [NUM_PORTS-1:0]      skip_i,
   input  logic [NUM_PORTS-1:0]      sent_i,
   input  logic                      no_hit_i,
   input  logic                      multiple_hit_i,
   input  logic                      no_prot_i,
   input  logic [AXI_ADDR_WIDTH-1:0] out_addr_i,
   input  logic                      master_select_i,
   output logic [NUM_PORTS-1:0]      port_sel_o,
   output logic [NUM_PORTS-1:0]      accept_o,
   output logic [NUM_PORTS-1:0]      drop_o,
   output logic [IDX_W-1:0]          grant_idx_o,
   output logic [AXI_ADDR_WIDTH-1:0] out_addr_reg_o,
   output logic                      master_select_reg_o,
   output logic                      busy_o,
   output logic                      int_miss_o,
   output logic                      int_multi_o,
   output logic                      int_prot_o,
   output logic                      int_timeout_o
);

   typedef enum logic {ST_READY = 1'b0, ST_WAIT = 1'b1} state_e;

   state_e                    r_state;
   logic [IDX_W-1:0]          r_rr_ptr;
   logic [IDX_W-1:0]          r_grant_idx;
   logic [NUM_PORTS-1:0]      r_accept;
   logic [NUM_PORTS-1:0]      r_drop;
   logic [AXI_ADDR_WIDTH-1:0] r_out_addr;
   logic                      r_msel;
   logic                      r_int_miss;
   logic                      r_int_multi;
   logic                      r_int_prot;
   logic                      r_int_timeout;

   logic                      w_any;
   logic                      w_found;
   int                        w_scan;
   logic [IDX_W-1:0]          w_scan_idx;
   logic [IDX_W-1:0]          w_pick;
   logic [IDX_W-1:0]          w_rr_next;
   logic [NUM_PORTS-1:0]      w_onehot;
   logic                      w_err;
   logic                      w_sent;
   logic                      w_expire;

   // Scan starts at the round-robin pointer and wraps, so the last winner has lowest priority.
   always_comb begin
      w_found    = 1'b0;
      w_scan     = 0;
      w_scan_idx = '0;
      w_pick     = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         w_scan = int'(r_rr_ptr) + k;
         if (w_scan >= NUM_PORTS) w_scan = w_scan - NUM_PORTS;
         w_scan_idx = IDX_W'(w_scan);
         if (!w_found && addr_valid_i[w_scan_idx]) begin
            w_found = 1'b1;
            w_pick  = w_scan_idx;
         end
      end
   end

   assign w_any      = |addr_valid_i;
   assign w_rr_next  = (w_pick == IDX_W'(NUM_PORTS - 1)) ? '0 : w_pick + IDX_W'(1);
   assign w_onehot   = NUM_PORTS'(1) << w_pick;
   assign w_err      = no_hit_i | multiple_hit_i | ~no_prot_i | skip_i[w_pick];
   assign w_sent     = sent_i[r_grant_idx];
   assign port_sel_o = (r_state == ST_READY && w_any) ? w_onehot : '0;

   generate
      if (TIMEOUT_CYCLES > 0) begin : g_wdog
         localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
         logic [CNT_W-1:0] r_wdog_cnt;

         assign w_expire = (r_state == ST_WAIT) && !w_sent &&
                           (r_wdog_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

         always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
            if (!Rst_RBI) begin
               r_wdog_cnt <= '0;
            end else if (r_state != ST_WAIT || w_sent || w_expire) begin
               r_wdog_cnt <= '0;
            end else begin
               r_wdog_cnt <= r_wdog_cnt + CNT_W'(1);
            end
         end
      end else begin : g_no_wdog
         assign w_expire = 1'b0;
      end
   endgenerate

   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         r_state       <= ST_READY;
         r_rr_ptr      <= '0;
         r_grant_idx   <= '0;
         r_accept      <= '0;
         r_drop        <= '0;
         r_out_addr    <= '0;
         r_msel        <= 1'b0;
         r_int_miss    <= 1'b0;
         r_int_multi   <= 1'b0;
         r_int_prot    <= 1'b0;
         r_int_timeout <= 1'b0;
      end else begin
         r_accept      <= '0;
         r_drop        <= '0;
         r_int_miss    <= 1'b0;
         r_int_multi   <= 1'b0;
         r_int_prot    <= 1'b0;
         r_int_timeout <= 1'b0;
         case (r_state)
            ST_READY: begin
               if (w_any) begin
                  r_accept    <= w_err ? '0 : w_onehot;
                  r_drop      <= w_err ? w_onehot : '0;
                  r_int_miss  <= no_hit_i;
                  r_int_multi <= multiple_hit_i;
                  r_int_prot  <= ~no_prot_i;
                  r_out_addr  <= out_addr_i;
                  r_msel      <= master_select_i;
                  r_grant_idx <= w_pick;
                  r_rr_ptr    <= w_rr_next;
                  r_state     <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               // sent takes priority over a simultaneous watchdog expiry
               if (w_sent) begin
                  r_state <= ST_READY;
               end else if (w_expire) begin
                  r_int_timeout <= 1'b1;
                  r_state       <= ST_READY;
               end
            end
            default: r_state <= ST_READY;
         endcase
      end
   end

   assign accept_o            = r_accept;
   assign drop_o              = r_drop;
   assign grant_idx_o         = r_grant_idx;
   assign out_addr_reg_o      = r_out_addr;
   assign master_select_reg_o = r_msel;
   assign busy_o              = (r_state == ST_WAIT);
   assign int_miss_o          = r_int_miss;
   assign int_multi_o         = r_int_multi;
   assign int_prot_o          = r_int_prot;
   assign int_timeout_o       = r_int_timeout;

endmodule

// File: tb/tb_rab_lookup_arb_fsm.sv
// Bench for rab_lookup_arb_fsm: directed scenarios plus random traffic against a transaction-level model.
module tb_rab_lookup_arb_fsm;
   localparam int NP = 4;
   localparam int AW = 40;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NP-1:0] addr_valid, skip, sent;
   logic          no_hit, multi_hit, no_prot, msel;
   logic [AW-1:0] out_addr;

   logic [NP-1:0] port_sel, accept, drop;
   logic [1:0]    gidx;
   logic [AW-1:0] addr_reg;
   logic          msel_reg, busy, i_miss, i_multi, i_prot, i_to;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   int            m_rr, m_gidx, m_cnt;
   bit            m_busy;
   logic [NP-1:0] m_acc, m_drop;
   bit            m_miss, m_multi, m_prot, m_to, m_msel;
   logic [AW-1:0] m_addr;

   always #5 clk = ~clk;

   rab_lookup_arb_fsm #(
      .AXI_ADDR_WIDTH(AW),
      .NUM_PORTS(NP),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .Clk_CI(clk),
      .Rst_RBI(rst_n),
      .addr_valid_i(addr_valid),
      .skip_i(skip),
      .sent_i(sent),
      .no_hit_i(no_hit),
      .multiple_hit_i(multi_hit),
      .no_prot_i(no_prot),
      .out_addr_i(out_addr),
      .master_select_i(msel),
      .port_sel_o(port_sel),
      .accept_o(accept),
      .drop_o(drop),
      .grant_idx_o(gidx),
      .out_addr_reg_o(addr_reg),
      .master_select_reg_o(msel_reg),
      .busy_o(busy),
      .int_miss_o(i_miss),
      .int_multi_o(i_multi),
      .int_prot_o(i_prot),
      .int_timeout_o(i_to)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [NP-1:0] oh(input int i);
      logic [NP-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   function automatic int oh_idx(input logic [NP-1:0] v);
      for (int i = 0; i < NP; i++) if (v[i]) return i;
      return -1;
   endfunction

   // first requesting port at or after the round-robin pointer
   function automatic int m_pick();
      for (int k = 0; k < NP; k++) if (addr_valid[(m_rr + k) % NP]) return (m_rr + k) % NP;
      return -1;
   endfunction

   function automatic logic [NP-1:0] exp_sel();
      int p;
      p = m_pick();
      if (m_busy || p < 0) return '0;
      return oh(p);
   endfunction

   task automatic m_reset();
      m_rr = 0; m_gidx = 0; m_cnt = 0; m_busy = 0;
      m_acc = '0; m_drop = '0; m_addr = '0; m_msel = 0;
      m_miss = 0; m_multi = 0; m_prot = 0; m_to = 0;
   endtask

   task automatic m_step();
      int p;
      bit err;
      m_acc = '0; m_drop = '0;
      m_miss = 0; m_multi = 0; m_prot = 0; m_to = 0;
      if (!m_busy) begin
         p = m_pick();
         if (p >= 0) begin
            err = no_hit | multi_hit | !no_prot | skip[p];
            if (err) m_drop = oh(p);
            else     m_acc  = oh(p);
            m_miss  = no_hit;
            m_multi = multi_hit;
            m_prot  = !no_prot;
            m_addr  = out_addr;
            m_msel  = msel;
            m_gidx  = p;
            m_rr    = (p + 1) % NP;
            m_busy  = 1;
            m_cnt   = 0;
         end
      end else if (sent[m_gidx]) begin
         m_busy = 0;
      end else begin
         m_cnt++;
         if (m_cnt == TO) begin
            m_to   = 1;
            m_busy = 0;
         end
      end
   endtask

   task automatic check_outs();
      check_val("accept", accept, m_acc);
      check_val("drop", drop, m_drop);
      check_val("grant_idx", gidx, m_gidx);
      check_val("out_addr_reg", addr_reg, m_addr);
      check_val("msel_reg", msel_reg, m_msel);
      check_val("busy", busy, m_busy);
      check_val("int_miss", i_miss, m_miss);
      check_val("int_multi", i_multi, m_multi);
      check_val("int_prot", i_prot, m_prot);
      check_val("int_timeout", i_to, m_to);
   endtask

   // inputs are set at posedge+1; combinational check, model update, registered check at next posedge+1
   task automatic cycle();
      #1;
      check_val("port_sel", port_sel, exp_sel());
      m_step();
      @(posedge clk);
      #1;
      check_outs();
   endtask

   task automatic grant(input logic [NP-1:0] v, input logic [NP-1:0] sk, input bit nh, input bit mh,
                        input bit np_ok, input logic [AW-1:0] a, input bit ms);
      addr_valid = v; skip = sk; no_hit = nh; multi_hit = mh; no_prot = np_ok;
      out_addr = a; msel = ms; sent = '0;
      cycle();
      addr_valid = '0; skip = '0; no_hit = 0; multi_hit = 0; no_prot = 1;
   endtask

   task automatic release_port();
      sent = oh(m_gidx);
      cycle();
      sent = '0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL sim_time_limit got=expired exp=finished");
      $fatal(1, "time limit");
   end

   initial begin
      int gl[$];
      int gc[$];
      rst_n = 0;
      addr_valid = '0; skip = '0; sent = '0;
      no_hit = 0; multi_hit = 0; no_prot = 1; msel = 0; out_addr = '0;
      m_reset();
      #12;
      check_outs();
      check_val("rst_port_sel", port_sel, 0);
      rst_n = 1;
      @(posedge clk);
      #1;

      // single request on port 2
      grant(4'b0100, '0, 0, 0, 1, 40'h12_3456_7000, 1);
      check_val("t1_accept", accept, 4'b0100);
      check_val("t1_gidx", gidx, 2);
      check_val("t1_addr", addr_reg, 40'h12_3456_7000);
      check_val("t1_busy", busy, 1);
      release_port();
      check_val("t1_busy_after_sent", busy, 0);

      // skip alone: drop, no interrupt; also moves pointer back to 0
      grant(4'b1000, 4'b1000, 0, 0, 1, AW'(40'h00_0ABC_D000), 0);
      check_val("skip_drop", drop, 4'b1000);
      check_val("skip_accept", accept, 0);
      check_val("skip_ints", {i_miss, i_multi, i_prot}, 0);
      release_port();

      // round-robin fairness with sent on the second wait cycle
      addr_valid = 4'b1111;
      for (int c = 0; c < 14; c++) begin
         sent = (m_busy && m_cnt == 1) ? oh(m_gidx) : '0;
         out_addr = AW'({$urandom, $urandom});
         cycle();
         if (accept != '0) begin
            gl.push_back(oh_idx(accept));
            gc.push_back(c);
         end
      end
      addr_valid = '0;
      sent = '0;
      check_val("rr_count", gl.size(), 5);
      for (int k = 0; k < gl.size() && k < 5; k++) begin
         check_val("rr_order", gl[k], k % NP);
         if (k > 0) check_val("rr_spacing", gc[k] - gc[k-1], 3);
      end
      if (m_busy) release_port();

      // error mapping
      grant(4'b0010, '0, 1, 0, 1, AW'(40'h01_0000_0000), 0);
      check_val("miss_drop", drop, 4'b0010);
      check_val("miss_int", i_miss, 1);
      release_port();
      check_val("miss_int_one_cycle", i_miss, 0);
      grant(4'b0001, '0, 0, 1, 1, AW'(40'h02_0000_0000), 1);
      check_val("multi_int", i_multi, 1);
      check_val("multi_drop", drop, 4'b0001);
      release_port();
      grant(4'b0100, '0, 0, 0, 0, AW'(40'h03_0000_0000), 0);
      check_val("prot_int", i_prot, 1);
      check_val("prot_drop", drop, 4'b0100);
      release_port();

      // foreign sent ignored
      grant(4'b0001, '0, 0, 0, 1, AW'(40'h04_0000_0000), 0);
      sent = 4'b0010;
      for (int k = 0; k < 5; k++) begin
         cycle();
         check_val("foreign_busy", busy, 1);
      end
      sent = 4'b0001;
      cycle();
      check_val("own_sent_busy", busy, 0);
      sent = '0;

      // watchdog expiry
      grant(4'b0010, '0, 0, 0, 1, AW'(40'h05_0000_0000), 0);
      for (int k = 1; k <= TO; k++) begin
         cycle();
         check_val("wd_timeout", i_to, (k == TO));
         check_val("wd_busy", busy, (k != TO));
      end
      cycle();
      check_val("wd_timeout_pulse_end", i_to, 0);

      // sent in the expiry cycle wins
      grant(4'b0100, '0, 0, 0, 1, AW'(40'h06_0000_0000), 0);
      for (int k = 1; k < TO; k++) cycle();
      sent = 4'b0100;
      cycle();
      check_val("wd_sent_wins_to", i_to, 0);
      check_val("wd_sent_wins_busy", busy, 0);
      sent = '0;

      // async reset mid-WAIT with pointer at 2
      grant(4'b0010, '0, 0, 0, 1, AW'(40'h07_0000_0000), 1);
      #3;
      rst_n = 0;
      #1;
      m_reset();
      check_outs();
      check_val("arst_port_sel", port_sel, 0);
      @(posedge clk);
      #1;
      rst_n = 1;
      addr_valid = 4'b1111;
      cycle();
      check_val("arst_regrant", accept, 4'b0001);
      check_val("arst_gidx", gidx, 0);
      release_port();
      addr_valid = '0;

      // random traffic
      for (int n = 0; n < 400; n++) begin
         addr_valid = ($urandom_range(0, 3) == 0) ? '0 : NP'($urandom);
         skip       = ($urandom_range(0, 7) == 0) ? NP'($urandom) : '0;
         no_hit     = ($urandom_range(0, 7) == 0);
         multi_hit  = ($urandom_range(0, 9) == 0);
         no_prot    = ($urandom_range(0, 7) != 0);
         out_addr   = AW'({$urandom, $urandom});
         msel       = 1'($urandom);
         sent       = NP'($urandom) & ~oh(m_gidx);
         if ($urandom_range(0, 9) == 0) sent = sent | oh(m_gidx);
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
